tcdm_bank_rmw_adapter: RTL
==========================

# tcdm_bank_rmw_adapter

Per-bank endpoint that sits directly downstream of one crossbar slave port, between the crossbar's `req_o`/`gnt_i`/`wdata_o`/`rdata_i` and a single-port SRAM macro without byte enables. It unpacks the packed request word and performs reads, full-word writes, and read-modify-write for partial (byte-enabled) stores. Read data returns with the fixed response latency the crossbar is configured for.

## Interface
Parameters:
- `DataWidth`, 32: SRAM word width; multiple of 8.
- `AddrWidth`, 10: bank-local word address width.
- `RespLat`, 1: cycles from grant to `rdata_o`; ≥1; must equal the crossbar's `RespLat`.
- `ReqDataWidth`, derived localparam = 1 + DataWidth/8 + AddrWidth + DataWidth; must equal the crossbar's `ReqDataWidth`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `req_i` in 1: request from crossbar `req_o[k]`.
- `gnt_o` out 1: grant to crossbar `gnt_i[k]`.
- `wdata_i` in ReqDataWidth: packed {wen, be[DataWidth/8], addr[AddrWidth], data[DataWidth]}, MSB first; wen=1 means store.
- `rdata_o` out DataWidth: response data to crossbar `rdata_i[k]`.
- `mem_req_o` out 1: SRAM access enable.
- `mem_we_o` out 1: SRAM write enable.
- `mem_addr_o` out AddrWidth: SRAM address.
- `mem_wdata_o` out DataWidth: SRAM write data.
- `mem_rdata_i` in DataWidth: SRAM read data, valid exactly 1 cycle after a read access.

## Operation
- FSM states:
  - IDLE: `gnt_o`=1.
  - MERGE: `gnt_o`=0.
- `gnt_o` = (state==IDLE) & ~rst_i. It never depends on `req_i`, so no combinational loop exists with the arbiter.
- A transaction is accepted when `req_i & gnt_o`. Behaviour in IDLE by request type:
  - Load (wen=0): SRAM read at addr.
  - Full store (wen=1, be all ones): SRAM write of data at addr.
  - Empty store (wen=1, be=0): no SRAM access; response still produced.
  - Partial store (wen=1, be neither 0 nor all ones): SRAM read at addr; latch be, addr, data; go to MERGE.
- MERGE, one cycle: SRAM write at the latched addr with (mem_rdata_i & ~bytemask) | (data & bytemask), where bytemask expands each be bit to 8 bits. Return to IDLE.
- A request presented during MERGE waits (not granted). It is accepted in the following IDLE cycle and therefore sees the merged data.
- Response pipeline: a RespLat-deep tag pipeline marks load slots.
  - A load's data is captured from `mem_rdata_i` at stage 1.
  - Load data is forwarded through RespLat-1 further registers.
  - Non-load slots (stores, idle cycles) carry 0, so `rdata_o`=0 for write responses and idle cycles.
- RespLat=1: `rdata_o` is the stage-1 register.

## Timing
- Reset: while `rst_i`=1, `gnt_o`=0, `mem_req_o`=0, `mem_we_o`=0. State goes to IDLE and all pipeline registers clear, so `rdata_o`=0 in the first cycle after reset.
- Reset during MERGE: the merge write is dropped (`mem_req_o`=0 in the reset cycle), and a partial store granted before reset leaves memory unchanged.
- Load granted in cycle t: `mem_req_o`=1, `mem_we_o`=0 in t; `rdata_o` valid in t+RespLat.
- Back-to-back loads: one per cycle, no bubbles.
- Partial store granted in t: read in t, merge write in t+1, `gnt_o`=0 in t+1. Next grant is no earlier than t+2.
- `mem_addr_o` and `mem_wdata_o` are don't-care when `mem_req_o`=0 but must not be X after reset; drive 0.

## Structure
- Package `tcdm_bank_pkg`:
  - state enum `bank_state_e` {IDLE, MERGE}.
  - function `be_to_mask` (byte enable to bit mask).
  - field-offset helper functions for the packed request word; the crossbar-side packer uses the same functions.
- Sub-module `tcdm_resp_pipe`: a RespLat-deep shift register of {tag, data} with synchronous clear.
- Elaboration assertions: RespLat≥1; DataWidth%8==0.

## Test plan
- Reset: assert `rst_i` 3 cycles with `req_i`=1 → `gnt_o`=0, `mem_req_o`=0 throughout; `rdata_o`=0 the cycle after release.
- Full store then load, RespLat=1: store 0xDEADBEEF at addr 5, then load addr 5 next cycle → `rdata_o`=0xDEADBEEF exactly 1 cycle after the load grant; `rdata_o`=0 in the store's response slot.
- Partial store with RAW (read-after-write): memory[7]=0x11223344; store be=4'b0101, data=0xAABBCCDD at 7, with a load of 7 presented on the next cycle → `gnt_o` low 1 cycle; SRAM write data 0x11BB33DD; load returns 0x11BB33DD.
- Empty store: be=0 at addr 3 → granted, `mem_req_o`=0, memory unchanged, `rdata_o`=0 in the response slot.
- Reset mid-MERGE: `rst_i` in the MERGE cycle of a be=4'b0001 store to addr 9 → no SRAM write; memory[9] unchanged; FSM in IDLE after reset.
- RespLat=3 streaming: 8 consecutive loads of addrs 0..7 → `rdata_o` values in order at grant+3, no gaps, `gnt_o` constantly 1.

Source files
------------

// File: rtl/tcdm_bank_pkg.sv
// Shared types and helpers for the TCDM bank endpoint: FSM states, packed
// request field offsets (also used by the crossbar-side packer) and byte-mask expansion.
package tcdm_bank_pkg;

  localparam int MaxDataWidth = 1024;
  localparam int MaxBeWidth   = MaxDataWidth / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } bank_state_e;

  // Request word layout, MSB first: {wen, be, addr, data}.
  function automatic int addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int be_lsb(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

  function automatic int wen_pos(input int data_width, input int addr_width);
    return data_width + addr_width + data_width / 8;
  endfunction

  function automatic int req_data_width(input int data_width, input int addr_width);
    return wen_pos(data_width, addr_width) + 1;
  endfunction

  function automatic logic [MaxDataWidth-1:0] be_to_mask(input logic [MaxBeWidth-1:0] be);
    logic [MaxDataWidth-1:0] mask;
    mask = '0;
    for (int i = 0; i < MaxBeWidth; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-latency response pipeline: stage 1 gates the SRAM read data with the load
// tag, later stages forward it unchanged so non-load slots always read as zero.
module tcdm_resp_pipe #(
  parameter int Depth     = 1,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic                 tag_q;
  logic [DataWidth-1:0] stage1_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbour, giving a true shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) tag_q <= 1'b0;
    else       tag_q <= load_i;
  end

  assign stage1_data = tag_q ? mem_rdata_i : '0;

  if (Depth == 1) begin : g_lat1
    assign rdata_o = stage1_data;
  end else begin : g_latn
    logic [DataWidth-1:0] fwd_q [Depth-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth - 1; i++) fwd_q[i] <= '0;
      end else begin
        fwd_q[0] <= stage1_data;
        for (int i = 1; i < Depth - 1; i++) fwd_q[i] <= fwd_q[i-1];
      end
    end

    assign rdata_o = fwd_q[Depth-2];
  end

endmodule

// File: rtl/tcdm_bank_rmw_adapter.sv
// Per-bank crossbar endpoint driving a single-port SRAM without byte enables;
// partial stores become a read followed by a merged full-word write.
module tcdm_bank_rmw_adapter
  import tcdm_bank_pkg::*;
#(
  parameter  int DataWidth    = 32,
  parameter  int AddrWidth    = 10,
  parameter  int RespLat      = 1,
  localparam int ReqDataWidth = req_data_width(DataWidth, AddrWidth)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ReqDataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrWidth-1:0]    mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int BeWidth = DataWidth / 8;
  localparam int BeLsb   = be_lsb(DataWidth, AddrWidth);
  localparam int AddrLsb = addr_lsb(DataWidth);
  localparam int WenPos  = wen_pos(DataWidth, AddrWidth);

  if (RespLat < 1) begin : g_bad_lat
    $fatal(1, "tcdm_bank_rmw_adapter: RespLat must be at least 1");
  end
  if (DataWidth % 8 != 0 || DataWidth > MaxDataWidth) begin : g_bad_width
    $fatal(1, "tcdm_bank_rmw_adapter: DataWidth must be a multiple of 8");
  end

  logic                 req_wen;
  logic [BeWidth-1:0]   req_be;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_data;

  assign req_wen  = wdata_i[WenPos];
  assign req_be   = wdata_i[BeLsb +: BeWidth];
  assign req_addr = wdata_i[AddrLsb +: AddrWidth];
  assign req_data = wdata_i[DataWidth-1:0];

  bank_state_e          state_q, state_d;
  logic                 accept, load_accept, latch_en;
  logic [BeWidth-1:0]   be_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic [DataWidth-1:0] byte_mask;

  // Grant is a pure function of state and reset so it never loops back through the arbiter.
  assign gnt_o       = (state_q == IDLE) & ~rst_i;
  assign accept      = req_i & gnt_o;
  assign load_accept = accept & ~req_wen;
  assign byte_mask   = DataWidth'(be_to_mask(MaxBeWidth'(be_q)));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    latch_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_wen) begin
            mem_req_o  = 1'b1;
            mem_addr_o = req_addr;
          end else if (&req_be) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = req_addr;
            mem_wdata_o = req_data;
          end else if (|req_be) begin
            mem_req_o  = 1'b1;
            mem_addr_o = req_addr;
            latch_en   = 1'b1;
            state_d    = MERGE;
          end
        end
      end
      MERGE: begin
        // A reset landing here drops the write so memory keeps its old word.
        if (!rst_i) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_q;
          mem_wdata_o = (mem_rdata_i & ~byte_mask) | (data_q & byte_mask);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the latched store fields carry no reset; they are only consumed in
  // MERGE, which is always entered through a load of these registers.
  always_ff @(posedge clk_i) begin
    if (latch_en) begin
      be_q   <= req_be;
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  tcdm_resp_pipe #(
    .Depth    (RespLat),
    .DataWidth(DataWidth)
  ) u_resp_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_accept),
    .mem_rdata_i(mem_rdata_i),
    .rdata_o    (rdata_o)
  );

endmodule
